// File: rtl/bg_palette_fade_ctrl.sv
// Background-layer palette controller: a 16-entry RGB444 register file with a
// registered faded lookup, plus a frame-synchronous fade-out/fade-in sequencer.
module bg_palette_fade_ctrl #(
    parameter int unsigned FRAMES_PER_STEP = 4,
    parameter int unsigned ENTRIES         = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_start,
    input  logic [3:0]  index,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [11:0] wr_data,
    input  logic [1:0]  fade_cmd,
    input  logic        fade_go,
    output logic [3:0]  level,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {StIdle, StWait, StStep} state_t;

    localparam logic [7:0] LastCnt = 8'(FRAMES_PER_STEP - 1);

    state_t      state_q, state_d;
    logic [3:0]  level_q, level_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        fade_out_q, fade_out_d;
    logic        done_q, done_d;

    logic [11:0] pal_q [ENTRIES];
    logic [3:0]  red_q, green_q, blue_q;
    logic [3:0]  dim;
    logic [11:0] entry;

    function automatic logic [3:0] fade_chan(input logic [3:0] base, input logic [3:0] sub);
        return (base > sub) ? base - sub : 4'h0;
    endfunction

    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        cnt_d      = cnt_q;
        fade_out_d = fade_out_q;
        done_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (fade_go && fade_cmd == 2'b01) begin
                    if (level_q != 4'h0) begin
                        fade_out_d = 1'b1;
                        cnt_d      = 8'h00;
                        state_d    = StWait;
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (fade_go && fade_cmd == 2'b10) begin
                    if (level_q != 4'hF) begin
                        fade_out_d = 1'b0;
                        cnt_d      = 8'h00;
                        state_d    = StWait;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StWait: begin
                if (frame_start) begin
                    if (cnt_q == LastCnt) begin
                        cnt_d   = 8'h00;
                        state_d = StStep;
                    end else begin
                        cnt_d = cnt_q + 8'h01;
                    end
                end
            end
            StStep: begin
                level_d = fade_out_q ? level_q - 4'h1 : level_q + 4'h1;
                if (level_d == (fade_out_q ? 4'h0 : 4'hF)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    state_d = StWait;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= StIdle;
            level_q    <= 4'hF;
            cnt_q      <= 8'h00;
            fade_out_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            cnt_q      <= cnt_d;
            fade_out_q <= fade_out_d;
            done_q     <= done_d;
        end
    end

    // Lookup reads the pre-write contents, so a same-cycle write returns the old entry.
    assign entry = pal_q[index];
    assign dim   = 4'hF - level_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                pal_q[i] <= 12'h000;
            end
            red_q   <= 4'h0;
            green_q <= 4'h0;
            blue_q  <= 4'h0;
        end else begin
            if (wr_en) begin
                pal_q[wr_addr] <= wr_data;
            end
            red_q   <= fade_chan(entry[11:8], dim);
            green_q <= fade_chan(entry[7:4], dim);
            blue_q  <= fade_chan(entry[3:0], dim);
        end
    end

    assign red   = red_q;
    assign green = green_q;
    assign blue  = blue_q;
    assign level = level_q;
    assign busy  = (state_q != StIdle);
    assign done  = done_q;

endmodule

// File: doc/bg_palette_fade_ctrl.md
Name: bg_palette_fade_ctrl

Overview:
- Run-time palette controller for a background layer.
- Holds a 16-entry RGB444 palette register file that a loader can rewrite at any time.
- Serves per-pixel colour lookups with a registered output.
- Sequences frame-synchronous fade-out (to black) and fade-in (to full brightness) by stepping a global brightness level.

Parameters:
- FRAMES_PER_STEP, 4, frames between brightness steps; legal range 1..255.
- ENTRIES, 16, palette depth; fixed at 16 so the index is 4 bits.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- index  in  4  pixel palette index for lookup.
- red  out  4  faded red component of palette[index], registered.
- green  out  4  faded green component, registered.
- blue  out  4  faded blue component, registered.
- wr_en  in  1  write strobe for the palette entry.
- wr_addr  in  4  entry to write.
- wr_data  in  12  {R,G,B} nibbles, with R in [11:8].
- fade_cmd  in  2  00 none, 01 fade out, 10 fade in, 11 reserved (treated as none).
- fade_go  in  1  one-cycle pulse that starts fade_cmd.
- level  out  4  current brightness, 15 = full.
- busy  out  1  high while a fade is in progress.
- done  out  1  one-cycle pulse when a fade reaches its target.

Behaviour:
- Reset (asynchronous, active-high; also mid-fade):
  - All palette entries = 12'h000; level = 15; state IDLE; frame counter = 0.
  - red/green/blue = 0; busy = 0; done = 0.
- Lookup:
  - 1-cycle latency: index is sampled at edge N, and colour is valid after edge N.
  - Each component = max(base − (15 − level), 0), computed as a 4-bit saturating subtract with no wrap.
  - level changes take effect on the lookup issued in the cycle after level updates.
- Write:
  - Always accepted, with no backpressure; entry updates at the edge where wr_en = 1.
  - Same-cycle lookup of the address being written returns the OLD value (read-before-write). The next cycle returns the new value.
  - Writes are permitted during a fade and are faded at the current level.
- State machine: IDLE, WAIT, STEP.
  - IDLE: on fade_go with cmd 01 and level > 0, or cmd 10 and level < 15, latch direction, clear the frame counter, go to WAIT, and set busy = 1.
  - IDLE, fade_go already at target (01 with level = 0, or 10 with level = 15): stay IDLE; done pulses the next cycle; busy stays 0.
  - IDLE, fade_go with cmd 00 or 11: ignored.
  - WAIT: each frame_start increments the frame counter. When the counter reaches FRAMES_PER_STEP − 1 and frame_start = 1, clear the counter and go to STEP.
  - STEP (one cycle): level −1 for fade out, +1 for fade in.
    - If the new level = target (0 or 15): go to IDLE, busy = 0, and done = 1 in the same cycle.
    - Otherwise: return to WAIT.
  - fade_go while busy: ignored (no retarget, no restart).
- A fade covering the full range takes 15 × FRAMES_PER_STEP frame_start pulses.
- frame_start in the same cycle as fade_go: the pulse is not counted; counting starts from the next frame_start.
- Frame counter is 8 bits. With FRAMES_PER_STEP = 1, every frame_start in WAIT produces a STEP.
- done is never asserted together with a new busy rise.

Test Plan:
- Reset, then write entry 3 = 12'hF84, then lookup index 3 → colour after 1 cycle = F,8,4; level = 15; busy = 0.
- Write entry 5 = 12'hABC while index = 5 in the same cycle → output = old 0,0,0; next cycle → A,B,C.
- FRAMES_PER_STEP = 4, entry 3 = F84, fade_go with cmd 01 → level goes 14 after 4 frame_starts, and 11 after 16. Entry 3 at level 11 reads B,4,0. done pulses once after 60 frame_starts with level = 0, and all outputs read 0.
- Fade out at level 0, then fade_go with cmd 10 → level reaches 15 after 60 frame_starts; entry 3 reads F,8,4; done pulses once.
- fade_go with cmd 01 at level 0 → busy stays 0; done pulses 1 cycle later. A second fade_go while busy mid-fade → no change to timing or direction.
- Assert Reset mid-fade at level 9 → level = 15, busy = 0, entries = 000 immediately (asynchronous). Subsequent frame_starts do not change level.
